rv32_decode_stage: RTL and testbench
====================================

Name: rv32_decode_stage

Overview:
- Registered RV32I instruction decode stage, sitting between fetch and execute.
- Accepts instr/pc from fetch over a valid/ready handshake and emits the control encodings consumed by the ALU, branch comparator, sign-extender and PC-select logic.
- Inserts a single bubble on a load-use hazard.
- Holds in a trap state after an illegal instruction until flushed.

Parameters:
- PC_W, 32, width of PC carried alongside the instruction.
- LOAD_USE_STALL, 1, 1 = bubble insertion enabled; 0 = hazard check tied off.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage accepts this cycle
- if_instr  in  32  instruction word
- if_pc  in  PC_W  instruction PC
- flush  in  1  redirect; kill held and incoming instructions
- id_ready  in  1  execute accepts output
- id_valid  out  1  output register holds a valid instruction
- id_pc  out  PC_W  registered PC
- id_rs1, id_rs2, id_rd  out  5 each  register indices
- id_imm_raw  out  25  instr[31:7], for the sign-extender
- id_sext  out  3  sext_ctrl_t
- id_alu  out  4  alu_ctrl_t
- id_br  out  3  br_func_t
- id_pc_src  out  2  pc_source_t
- id_op_a  out  2  0 = rs1, 1 = PC, 2 = zero
- id_op_b_imm  out  1  ALU operand B is the immediate
- id_reg_wr, id_mem_rd, id_mem_wr  out  1 each
- id_mem_size  out  3  funct3 of load/store
- id_wb_sel  out  2  0 = ALU, 1 = MEM, 2 = PC+4
- id_illegal  out  1  held instruction is illegal

Behaviour:
- Reset: id_valid=0, every control output 0, id_br=BR_NONE, id_pc_src=PC_INC, state=RUN.
- Latency: one cycle from the accept edge to id_valid.
- Accept condition: if_valid && if_ready at the clock edge.
- if_ready = state==RUN && !flush && !hazard && (!id_valid || id_ready).
- Output register:
  - Loads on accept.
  - Clears id_valid when id_ready && !accept.
  - Otherwise holds all fields stable while id_valid && !id_ready.
- Hazard (LOAD_USE_STALL=1): id_valid && id_ready && id_mem_rd && id_rd!=0 && the incoming instruction reads id_rd (via rs1 or rs2). Next cycle id_valid=0, giving exactly one bubble.
- Register usage:
  - rs1 read by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 read by OP, STORE, BRANCH.
- Flush is synchronous and highest priority: next cycle id_valid=0 and state=RUN; the incoming instruction is not accepted.
- FSM:
  - RUN -> TRAP when an illegal instruction is accepted.
  - TRAP -> RUN only on flush.
  - In TRAP, if_ready=0. The illegal entry is presented with id_illegal=1, reg_wr/mem_rd/mem_wr=0, BR_NONE, PC_INC.
- Decode, opcode -> fields (defaults: BR_NONE, PC_INC, ALU_ADD, op_a=rs1):
  - OP 0110011: alu from funct3; funct7[5] selects SUB/SRA; funct7 other than 0x00/0x20 (or 0x20 with funct3 not 000/101) -> illegal; reg_wr; wb ALU.
  - OP-IMM 0010011: sext_I_type, imm; SLLI needs funct7=0; SRLI/SRAI need funct7 0x00/0x20.
  - LOAD 0000011: sext_I_type, imm, ADD, mem_rd, reg_wr, wb MEM; funct3 011/110/111 illegal.
  - STORE 0100011: sext_S_type, imm, ADD, mem_wr; funct3 >010 illegal.
  - BRANCH 1100011: br=funct3 (010/011 illegal), sext_B_type, op_a=PC, imm, PC_BR.
  - JAL 1101111: sext_J_type, op_a=PC, imm, PC_JAL, reg_wr, wb PC+4.
  - JALR 1100111: funct3 must be 000; sext_I_type, op_a=rs1, imm, PC_JAL, reg_wr, wb PC+4.
  - LUI 0110111: sext_U_type, op_a=zero, imm, reg_wr.
  - AUIPC 0010111: sext_U_type, op_a=PC, imm, reg_wr.
  - Any other opcode, or instr[1:0]!=11: illegal.

Decomposition:
- Existing packages supply the output types: br_definitions, alu_definitions, sext_definitions, pc_defnitions.
- Add package decode_definitions with:
  - opcode_t enum (9 opcodes above).
  - op_a_sel_t (REG, PC, ZERO).
  - wb_sel_t (ALU, MEM, PC4).
  - id_state_t (RUN, TRAP).
- Sub-module rv32_decode_comb: purely combinational instr -> control bundle plus illegal, rs-usage flags. The stage wraps it with the handshake, hazard logic and FSM.

Test Plan:
- add x3,x1,x2 (0x002081B3), id_ready=1 -> next cycle id_valid=1, ALU_ADD, rd=3, reg_wr=1, wb ALU, BR_NONE, PC_INC.
- srai x4,x1,3 (0x4030D213) -> ALU_SRA, sext_I_type, op_b_imm=1. Then sub x3,x1,x2 (0x402081B3) -> ALU_SUB.
- lw x5,0(x1) (0x0000A283) followed by add x6,x5,x0 (0x00028333) -> if_ready=0 for one cycle, one id_valid=0 bubble, then add presented.
- beq x1,x2,8 (0x00208463) with id_ready=0 for 3 cycles -> outputs held: BR_BEQ, PC_BR, sext_B_type, op_a=PC; if_ready=0 throughout.
- 0x00000000 -> id_illegal=1, reg_wr/mem_wr=0, FSM in TRAP, if_ready stays 0 for 10 cycles; flush -> id_valid=0, next add accepted.
- rst_n asserted mid-stall with id_valid=1 -> id_valid=0 immediately (asynchronous); after release if_ready=1.

Source files
------------

// File: rtl/rv32_decode_stage_pkg.sv
// Control-encoding packages shared by the RV32I decode stage and its consumers.
// Each downstream unit owns its encoding; decode_definitions adds the stage-local types.
package br_definitions;
  // BR_NONE sits on funct3 010, which RV32I leaves unused for branches.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_NONE = 3'b010,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_func_t;
endpackage

package alu_definitions;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ctrl_t;
endpackage

package sext_definitions;
  typedef enum logic [2:0] {
    sext_I_type, sext_S_type, sext_B_type, sext_U_type, sext_J_type
  } sext_ctrl_t;
endpackage

package pc_defnitions;
  typedef enum logic [1:0] {PC_INC, PC_BR, PC_JAL} pc_source_t;
endpackage

package decode_definitions;
  import br_definitions::*;
  import alu_definitions::*;
  import sext_definitions::*;
  import pc_defnitions::*;

  typedef enum logic [6:0] {
    OpcOp     = 7'b0110011,
    OpcOpImm  = 7'b0010011,
    OpcLoad   = 7'b0000011,
    OpcStore  = 7'b0100011,
    OpcBranch = 7'b1100011,
    OpcJal    = 7'b1101111,
    OpcJalr   = 7'b1100111,
    OpcLui    = 7'b0110111,
    OpcAuipc  = 7'b0010111
  } opcode_t;

  typedef enum logic [1:0] {OpaReg = 2'd0, OpaPc = 2'd1, OpaZero = 2'd2} op_a_sel_t;
  typedef enum logic [1:0] {WbAlu = 2'd0, WbMem = 2'd1, WbPc4 = 2'd2} wb_sel_t;
  typedef enum logic [0:0] {StRun, StTrap} id_state_t;

  typedef struct packed {
    sext_ctrl_t sext;
    alu_ctrl_t  alu;
    br_func_t   br;
    pc_source_t pc_src;
    op_a_sel_t  op_a;
    logic       op_b_imm;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] mem_size;
    wb_sel_t    wb_sel;
  } ctrl_t;

  localparam ctrl_t CtrlDefault = '{
    sext: sext_I_type, alu: ALU_ADD, br: BR_NONE, pc_src: PC_INC, op_a: OpaReg,
    op_b_imm: 1'b0, reg_wr: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0, mem_size: 3'b000, wb_sel: WbAlu
  };

  // alt selects SUB over ADD and SRA over SRL.
  function automatic alu_ctrl_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_ctrl_t a;
    case (f3)
      3'b000:  a = alt ? ALU_SUB : ALU_ADD;
      3'b001:  a = ALU_SLL;
      3'b010:  a = ALU_SLT;
      3'b011:  a = ALU_SLTU;
      3'b100:  a = ALU_XOR;
      3'b101:  a = alt ? ALU_SRA : ALU_SRL;
      3'b110:  a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction
endpackage

// File: rtl/rv32_decode_stage_comb.sv
// Purely combinational RV32I decoder: instruction word to control bundle, legality
// and source-register usage flags.
module rv32_decode_comb
  import br_definitions::*;
  import alu_definitions::*;
  import sext_definitions::*;
  import pc_defnitions::*;
  import decode_definitions::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        rs1_used,
  output logic        rs2_used,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [24:0] imm_raw
);

  logic [2:0] f3;
  logic [6:0] f7;

  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign rd      = instr[11:7];
  assign imm_raw = instr[31:7];

  always_comb begin
    ctrl     = CtrlDefault;
    illegal  = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    // Full 7-bit match also rejects instr[1:0] != 2'b11.
    case (instr[6:0])
      OpcOp: begin
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        ctrl.reg_wr = 1'b1;
        ctrl.alu    = alu_from_funct3(f3, f7[5]);
        illegal     = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OpcOpImm: begin
        rs1_used      = 1'b1;
        ctrl.op_b_imm = 1'b1;
        ctrl.reg_wr   = 1'b1;
        ctrl.alu      = alu_from_funct3(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001) illegal = (f7 != 7'h00);
        if (f3 == 3'b101) illegal = (f7 != 7'h00) && (f7 != 7'h20);
      end
      OpcLoad: begin
        rs1_used      = 1'b1;
        ctrl.op_b_imm = 1'b1;
        ctrl.mem_rd   = 1'b1;
        ctrl.reg_wr   = 1'b1;
        ctrl.wb_sel   = WbMem;
        ctrl.mem_size = f3;
        illegal       = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OpcStore: begin
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        ctrl.sext     = sext_S_type;
        ctrl.op_b_imm = 1'b1;
        ctrl.mem_wr   = 1'b1;
        ctrl.mem_size = f3;
        illegal       = (f3 > 3'b010);
      end
      OpcBranch: begin
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        ctrl.br       = br_func_t'(f3);
        ctrl.sext     = sext_B_type;
        ctrl.op_a     = OpaPc;
        ctrl.op_b_imm = 1'b1;
        ctrl.pc_src   = PC_BR;
        illegal       = (f3[2:1] == 2'b01);
      end
      OpcJal: begin
        ctrl.sext     = sext_J_type;
        ctrl.op_a     = OpaPc;
        ctrl.op_b_imm = 1'b1;
        ctrl.pc_src   = PC_JAL;
        ctrl.reg_wr   = 1'b1;
        ctrl.wb_sel   = WbPc4;
      end
      OpcJalr: begin
        rs1_used      = 1'b1;
        ctrl.op_b_imm = 1'b1;
        ctrl.pc_src   = PC_JAL;
        ctrl.reg_wr   = 1'b1;
        ctrl.wb_sel   = WbPc4;
        illegal       = (f3 != 3'b000);
      end
      OpcLui: begin
        ctrl.sext     = sext_U_type;
        ctrl.op_a     = OpaZero;
        ctrl.op_b_imm = 1'b1;
        ctrl.reg_wr   = 1'b1;
      end
      OpcAuipc: begin
        ctrl.sext     = sext_U_type;
        ctrl.op_a     = OpaPc;
        ctrl.op_b_imm = 1'b1;
        ctrl.reg_wr   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // An illegal entry must not cause any architectural side effect downstream.
    if (illegal) begin
      ctrl.reg_wr = 1'b0;
      ctrl.mem_rd = 1'b0;
      ctrl.mem_wr = 1'b0;
      ctrl.br     = BR_NONE;
      ctrl.pc_src = PC_INC;
    end
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered RV32I decode stage: valid/ready handshake, one-bubble load-use stall
// and a trap hold after an illegal instruction until flushed.
module rv32_decode_stage
  import br_definitions::*;
  import alu_definitions::*;
  import sext_definitions::*;
  import pc_defnitions::*;
  import decode_definitions::*;
#(
  parameter int unsigned PC_W           = 32,
  parameter bit          LOAD_USE_STALL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  input  logic            flush,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [24:0]     id_imm_raw,
  output sext_ctrl_t      id_sext,
  output alu_ctrl_t       id_alu,
  output br_func_t        id_br,
  output pc_source_t      id_pc_src,
  output op_a_sel_t       id_op_a,
  output logic            id_op_b_imm,
  output logic            id_reg_wr,
  output logic            id_mem_rd,
  output logic            id_mem_wr,
  output logic [2:0]      id_mem_size,
  output wb_sel_t         id_wb_sel,
  output logic            id_illegal
);

  ctrl_t       dec_ctrl;
  logic        dec_illegal, dec_rs1_used, dec_rs2_used;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [24:0] dec_imm_raw;

  rv32_decode_comb u_decode_comb (
    .instr    (if_instr),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .rs1_used (dec_rs1_used),
    .rs2_used (dec_rs2_used),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .imm_raw  (dec_imm_raw)
  );

  id_state_t       state_q, state_d;
  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [24:0]     imm_raw_q, imm_raw_d;
  logic            illegal_q, illegal_d;
  logic            hazard, accept;

  // A load leaving this cycle cannot forward to the very next instruction.
  always_comb begin
    hazard = 1'b0;
    if (LOAD_USE_STALL) begin
      hazard = valid_q && id_ready && ctrl_q.mem_rd && (rd_q != 5'd0) &&
               ((dec_rs1_used && (dec_rs1 == rd_q)) || (dec_rs2_used && (dec_rs2 == rd_q)));
    end
  end

  assign if_ready = (state_q == StRun) && !flush && !hazard && (!valid_q || id_ready);
  assign accept   = if_valid && if_ready;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    imm_raw_d = imm_raw_q;
    illegal_d = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
      state_d = StRun;
    end else if (accept) begin
      valid_d   = 1'b1;
      ctrl_d    = dec_ctrl;
      pc_d      = if_pc;
      rs1_d     = dec_rs1;
      rs2_d     = dec_rs2;
      rd_d      = dec_rd;
      imm_raw_d = dec_imm_raw;
      illegal_d = dec_illegal;
      if (dec_illegal) state_d = StTrap;
    end else if (id_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      valid_q   <= 1'b0;
      ctrl_q    <= CtrlDefault;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_raw_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      pc_q      <= pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      imm_raw_q <= imm_raw_d;
      illegal_q <= illegal_d;
    end
  end

  assign id_valid    = valid_q;
  assign id_pc       = pc_q;
  assign id_rs1      = rs1_q;
  assign id_rs2      = rs2_q;
  assign id_rd       = rd_q;
  assign id_imm_raw  = imm_raw_q;
  assign id_sext     = ctrl_q.sext;
  assign id_alu      = ctrl_q.alu;
  assign id_br       = ctrl_q.br;
  assign id_pc_src   = ctrl_q.pc_src;
  assign id_op_a     = ctrl_q.op_a;
  assign id_op_b_imm = ctrl_q.op_b_imm;
  assign id_reg_wr   = ctrl_q.reg_wr;
  assign id_mem_rd   = ctrl_q.mem_rd;
  assign id_mem_wr   = ctrl_q.mem_wr;
  assign id_mem_size = ctrl_q.mem_size;
  assign id_wb_sel   = ctrl_q.wb_sel;
  assign id_illegal  = illegal_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: directed scenarios, then random traffic against a
// transaction-level model of the stage.
module tb_rv32_decode_stage;
  import br_definitions::*;
  import alu_definitions::*;
  import sext_definitions::*;
  import pc_defnitions::*;
  import decode_definitions::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0, flush = 1'b0, id_ready = 1'b1;
  logic [31:0] if_instr = 32'h0, if_pc = 32'h0;
  logic        if_ready, id_valid, id_op_b_imm, id_reg_wr, id_mem_rd, id_mem_wr, id_illegal;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [24:0] id_imm_raw;
  logic [2:0]  id_mem_size;
  sext_ctrl_t  id_sext;
  alu_ctrl_t   id_alu;
  br_func_t    id_br;
  pc_source_t  id_pc_src;
  op_a_sel_t   id_op_a;
  wb_sel_t     id_wb_sel;

  always #5 clk = ~clk;

  rv32_decode_stage #(.PC_W(32), .LOAD_USE_STALL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .flush(flush), .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm_raw(id_imm_raw),
    .id_sext(id_sext), .id_alu(id_alu), .id_br(id_br), .id_pc_src(id_pc_src),
    .id_op_a(id_op_a), .id_op_b_imm(id_op_b_imm), .id_reg_wr(id_reg_wr),
    .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_mem_size(id_mem_size),
    .id_wb_sel(id_wb_sel), .id_illegal(id_illegal)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected meaning of one instruction word, straight from the ISA rules.
  typedef struct {
    bit         illegal, rd1, rd2, has_imm, is_mem, reg_wr, mem_rd, mem_wr;
    alu_ctrl_t  alu;
    sext_ctrl_t sext;
    br_func_t   br;
    pc_source_t pc_src;
    op_a_sel_t  op_a;
    wb_sel_t    wb;
  } exp_t;

  alu_ctrl_t  alu_tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  logic [6:0] opcs [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    e.illegal = 0; e.rd1 = 0; e.rd2 = 0; e.has_imm = 0; e.is_mem = 0;
    e.reg_wr = 0; e.mem_rd = 0; e.mem_wr = 0;
    e.alu = ALU_ADD; e.sext = sext_I_type; e.br = BR_NONE; e.pc_src = PC_INC;
    e.op_a = OpaReg; e.wb = WbAlu;
    case (w[6:0])
      7'b0110011: begin
        e.rd1 = 1; e.rd2 = 1; e.reg_wr = 1;
        if (f7 == 7'h00) e.alu = alu_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'b000) e.alu = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'b101) e.alu = ALU_SRA;
        else e.illegal = 1;
      end
      7'b0010011: begin
        e.rd1 = 1; e.has_imm = 1; e.reg_wr = 1; e.alu = alu_tab[f3];
        if (f3 == 3'b001 && f7 != 7'h00) e.illegal = 1;
        if (f3 == 3'b101) begin
          if (f7 == 7'h20) e.alu = ALU_SRA;
          else if (f7 != 7'h00) e.illegal = 1;
        end
      end
      7'b0000011: begin
        e.rd1 = 1; e.has_imm = 1; e.is_mem = 1; e.mem_rd = 1; e.reg_wr = 1; e.wb = WbMem;
        if (f3 inside {3'b011, 3'b110, 3'b111}) e.illegal = 1;
      end
      7'b0100011: begin
        e.rd1 = 1; e.rd2 = 1; e.has_imm = 1; e.is_mem = 1; e.mem_wr = 1; e.sext = sext_S_type;
        if (f3 > 3'd2) e.illegal = 1;
      end
      7'b1100011: begin
        e.rd1 = 1; e.rd2 = 1; e.has_imm = 1; e.sext = sext_B_type; e.op_a = OpaPc;
        e.pc_src = PC_BR;
        if (f3 inside {3'b010, 3'b011}) e.illegal = 1;
        else e.br = br_func_t'(f3);
      end
      7'b1101111: begin
        e.has_imm = 1; e.sext = sext_J_type; e.op_a = OpaPc; e.pc_src = PC_JAL;
        e.reg_wr = 1; e.wb = WbPc4;
      end
      7'b1100111: begin
        e.rd1 = 1; e.has_imm = 1; e.pc_src = PC_JAL; e.reg_wr = 1; e.wb = WbPc4;
        if (f3 != 3'b000) e.illegal = 1;
      end
      7'b0110111: begin
        e.has_imm = 1; e.sext = sext_U_type; e.op_a = OpaZero; e.reg_wr = 1;
      end
      7'b0010111: begin
        e.has_imm = 1; e.sext = sext_U_type; e.op_a = OpaPc; e.reg_wr = 1;
      end
      default: e.illegal = 1;
    endcase
    if (e.illegal) begin
      e.reg_wr = 0; e.mem_rd = 0; e.mem_wr = 0; e.br = BR_NONE; e.pc_src = PC_INC;
    end
    return e;
  endfunction

  // Stage model: what the output register holds and whether the stage is trapped.
  bit          m_valid = 0, m_trap = 0;
  logic [31:0] m_instr = 32'h0, m_pc = 32'h0;

  task automatic check_outputs();
    exp_t e;
    chk("id_valid", id_valid, m_valid);
    if (m_valid) begin
      e = ref_dec(m_instr);
      chk("id_pc", id_pc, m_pc);
      chk("id_rs1", id_rs1, m_instr[19:15]);
      chk("id_rs2", id_rs2, m_instr[24:20]);
      chk("id_rd", id_rd, m_instr[11:7]);
      chk("id_imm_raw", id_imm_raw, m_instr[31:7]);
      chk("id_illegal", id_illegal, e.illegal);
      chk("id_reg_wr", id_reg_wr, e.reg_wr);
      chk("id_mem_rd", id_mem_rd, e.mem_rd);
      chk("id_mem_wr", id_mem_wr, e.mem_wr);
      chk("id_br", id_br, e.br);
      chk("id_pc_src", id_pc_src, e.pc_src);
      if (!e.illegal) begin
        chk("id_alu", id_alu, e.alu);
        chk("id_op_a", id_op_a, e.op_a);
        chk("id_op_b_imm", id_op_b_imm, e.has_imm);
        chk("id_wb_sel", id_wb_sel, e.wb);
        if (e.has_imm) chk("id_sext", id_sext, e.sext);
        if (e.is_mem) chk("id_mem_size", id_mem_size, m_instr[14:12]);
      end
    end
  endtask

  task automatic drive(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ir, input bit fl);
    if_valid = iv; if_instr = ins; if_pc = pc; id_ready = ir; flush = fl;
  endtask

  // One clock: check if_ready, advance the model across the edge, check the outputs.
  task automatic tick();
    exp_t ei, eh;
    bit   hz, rdy, acc;
    logic [4:0] hrd;
    #1;
    ei  = ref_dec(if_instr);
    eh  = ref_dec(m_instr);
    hrd = m_instr[11:7];
    hz  = m_valid && id_ready && eh.mem_rd && hrd != 5'd0 &&
          ((ei.rd1 && if_instr[19:15] == hrd) || (ei.rd2 && if_instr[24:20] == hrd));
    rdy = !m_trap && !flush && !hz && (!m_valid || id_ready);
    chk("if_ready", if_ready, rdy);
    acc = if_valid && rdy;
    @(posedge clk);
    if (flush) begin
      m_valid = 0; m_trap = 0;
    end else if (acc) begin
      m_valid = 1; m_instr = if_instr; m_pc = if_pc;
      if (ei.illegal) m_trap = 1;
    end else if (id_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic gen_instr(output logic [31:0] w);
    w = $urandom;
    if ($urandom_range(0, 15) != 0) begin
      w[6:0]   = opcs[$urandom_range(0, 8)];
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 7) != 0) begin
        case (w[6:0])
          7'b0110011, 7'b0010011: w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
          7'b0000011: w[14:12] = ld_f3[$urandom_range(0, 4)];
          7'b0100011: w[14:12] = 3'($urandom_range(0, 2));
          7'b1100011: w[14:12] = br_f3[$urandom_range(0, 5)];
          7'b1100111: w[14:12] = 3'b000;
          default: ;
        endcase
      end
    end
  endtask

  localparam logic [31:0] AddI  = 32'h002081B3;
  localparam logic [31:0] SraiI = 32'h4030D213;
  localparam logic [31:0] SubI  = 32'h402081B3;
  localparam logic [31:0] LwI   = 32'h0000A283;
  localparam logic [31:0] AddUI = 32'h00028333;
  localparam logic [31:0] BeqI  = 32'h00208463;

  initial begin
    logic [31:0] w;
    // Reset values while reset is held.
    #12;
    chk("rst_valid", id_valid, 0);
    chk("rst_alu", id_alu, ALU_ADD);
    chk("rst_br", id_br, BR_NONE);
    chk("rst_pc_src", id_pc_src, PC_INC);
    chk("rst_sext", id_sext, 0);
    chk("rst_op_a", id_op_a, 0);
    chk("rst_wb_sel", id_wb_sel, 0);
    chk("rst_reg_wr", id_reg_wr, 0);
    chk("rst_mem", {id_mem_rd, id_mem_wr}, 0);
    chk("rst_illegal", id_illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_if_ready", if_ready, 1);

    // add / srai / sub
    drive(1, AddI, 32'h100, 1, 0); tick();
    chk("add_valid", id_valid, 1);
    chk("add_alu", id_alu, ALU_ADD);
    chk("add_rd", id_rd, 3);
    chk("add_reg_wr", id_reg_wr, 1);
    chk("add_wb", id_wb_sel, WbAlu);
    chk("add_br", id_br, BR_NONE);
    chk("add_pc_src", id_pc_src, PC_INC);
    drive(1, SraiI, 32'h104, 1, 0); tick();
    chk("srai_alu", id_alu, ALU_SRA);
    chk("srai_sext", id_sext, sext_I_type);
    chk("srai_opb", id_op_b_imm, 1);
    drive(1, SubI, 32'h108, 1, 0); tick();
    chk("sub_alu", id_alu, ALU_SUB);

    // Load-use: exactly one bubble.
    drive(1, LwI, 32'h10C, 1, 0); tick();
    chk("lw_mem_rd", id_mem_rd, 1);
    drive(1, AddUI, 32'h110, 1, 0);
    #1 chk("lu_stall_rdy", if_ready, 0);
    tick();
    chk("lu_bubble", id_valid, 0);
    tick();
    chk("lu_add_valid", id_valid, 1);
    chk("lu_add_rd", id_rd, 6);

    // Branch held under backpressure.
    drive(1, BeqI, 32'h114, 1, 0); tick();
    drive(1, AddI, 32'h118, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("beq_hold_rdy", if_ready, 0);
      chk("beq_hold_br", id_br, BR_BEQ);
      chk("beq_hold_pc_src", id_pc_src, PC_BR);
      chk("beq_hold_sext", id_sext, sext_B_type);
      chk("beq_hold_op_a", id_op_a, OpaPc);
      chk("beq_hold_pc", id_pc, 32'h114);
    end
    drive(1, AddI, 32'h118, 1, 0); tick();
    chk("beq_next_pc", id_pc, 32'h118);

    // Illegal instruction traps until flushed.
    drive(1, 32'h0, 32'h11C, 1, 0); tick();
    chk("ill_flag", id_illegal, 1);
    chk("ill_reg_wr", id_reg_wr, 0);
    chk("ill_mem_wr", id_mem_wr, 0);
    chk("ill_br", id_br, BR_NONE);
    for (int i = 0; i < 10; i++) begin
      drive(1, AddI, 32'h120, (i >= 5), 0);
      tick();
      chk("trap_rdy", if_ready, 0);
    end
    drive(1, AddI, 32'h120, 1, 1); tick();
    chk("flush_valid", id_valid, 0);
    drive(1, AddI, 32'h124, 1, 0); tick();
    chk("post_flush_valid", id_valid, 1);
    chk("post_flush_illegal", id_illegal, 0);

    // Asynchronous reset in the middle of a stall.
    drive(1, LwI, 32'h128, 1, 0); tick();
    drive(1, AddI, 32'h12C, 0, 0); tick();
    chk("pre_rst_valid", id_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", id_valid, 0);
    m_valid = 0; m_trap = 0;
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_rdy", if_ready, 1);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      gen_instr(w);
      drive(($urandom_range(0, 3) != 0), w, $urandom, ($urandom_range(0, 3) != 0),
            m_trap ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
